vec_alu_multilane: RTL
======================

// Module: vec_alu_multilane
// PURPOSE
// Next-generation multi-lane vector ALU for the RVV coprocessor. Processes one vector
// instruction over VLEN-bit operands using 2^NB_LANES parallel lanes of 2^LANE_WIDTH bits.
// Adds add/sub with inter-chunk carry, or/xor, vl-based tail handling, v0 masking,
// a start/busy/done handshake and an illegal-op flag. Sits between vector regfile read and writeback.
// PARAMETERS
// VLEN        128  vector register width in bits (power of 2, >= 64)
// NB_LANES    1    log2 of lane count N
// LANE_WIDTH  3    log2 of lane width L in bits (3..6); N*L <= VLEN
// PORTS
// clk      in   1     clock, rising edge
// reset    in   1     asynchronous, active-high reset
// start    in   1     launch request; sampled only in IDLE
// opcode   in   6     000000 vadd, 000010 vsub (vs2-vs1), 001001 vand, 001010 vor, 001011 vxor
// vsew     in   3     element width E = 8<<vsew; 0..3 legal
// vl       in   VLEN_LOG2+1 active element count
// vm       in   1     1 = unmasked, 0 = element i active only if mask[i]
// mask     in   VLEN  v0 contents, bit i = element i
// vs1,vs2  in   VLEN  source operands
// vd_old   in   VLEN  old destination (masked-off/tail elements are kept undisturbed)
// busy     out  1     high during RUN
// done     out  1     one-cycle pulse when vd valid
// err      out  1     valid with done; 1 = illegal opcode or vsew
// vd       out  VLEN  result, held stable from done until next accepted start
// BEHAVIOUR
// - Reset (async): state IDLE, busy=0, done=0, err=0, vd=0, all counters/carries=0.
// - Operands/opcode/vsew/vl/vm/mask/vd_old are registered on the accepting cycle; inputs may change after.
// - FSM: IDLE -start-> RUN (or DONE directly if illegal or vl_eff==0); RUN -last chunk-> DONE; DONE -> IDLE (1 cycle).
// - start while busy or in DONE is ignored. start in IDLE on the DONE->IDLE cycle's successor is accepted.
// - vl_eff = min(vl, VLEN/E). On accept, vd is loaded with vd_old.
// - E <= L: each lane computes one whole element per cycle at E width; cycles = ceil(vl_eff/N).
// - E > L: element split into K=E/L chunks, LSB chunk first; lane i handles elements
//   base+i for K consecutive cycles; cycles = ceil(vl_eff/N)*K.
// - add/sub: per-lane carry register, cleared at chunk 0 of every element (sub: carry-in 1,
//   operand inverted); carry-out of last chunk discarded (modulo 2^E wrap).
// - Logical ops: bitwise, no carry.
// - Element j written only if j < vl_eff and (vm or mask[j]); otherwise vd keeps vd_old bits.
//   Lanes beyond vl_eff in the last group are idle.
// - done asserts the cycle after the last RUN cycle; err=1 → vd=vd_old, 1 cycle IDLE->DONE.
// - vl_eff==0 legal: done next cycle, err=0, vd=vd_old.
// - reset asserted mid-RUN: immediate return to IDLE, no done pulse, vd=0.
// TESTING (VLEN=128, NB_LANES=1, LANE_WIDTH=3: two 8-bit lanes)
// vand vsew=0 vl=16 vs1=0xF0..F0 vs2=0x3C..3C -> busy 8 cycles, done cycle 9, vd=0x30..30, err=0
// vadd vsew=2 vl=4, elem0 0x000000FF+0x00000001, elem1 0xFFFFFFFF+1 -> 8 RUN cycles, vd elem0=0x00000100, elem1=0x00000000
// vsub vsew=1 vl=8 vm=0 mask=0x55 vs2=0x0005 vs1=0x0007 -> even elems 0xFFFE, odd elems = vd_old
// vxor vsew=0 vl=3 vd_old=all 0xAA -> elems 0..2 computed, elems 3..15 = 0xAA; vl=200 clamps to 16
// opcode=111111 -> done cycle after start, err=1, vd=vd_old; vl=0 -> done, err=0, vd=vd_old
// reset pulse at RUN cycle 3 of a vadd -> busy=0, done never pulses, vd=0; next start runs normally

Source files
------------

// File: rtl/vec_alu_multilane.sv
// Multi-lane vector ALU: add/sub/and/or/xor over VLEN-bit operands.
// 2^NB_LANES lanes of 2^LANE_WIDTH bits each. Elements wider than a lane
// are processed LSB chunk first, and a per-lane carry links the chunks.
// Tail handling follows vl, and v0 masking follows vm/mask.
//
// Handshake: start is sampled only in IDLE. busy is high in every RUN cycle.
// done is a one-cycle pulse in DONE, and err is valid while done is high.
// vd holds its value from done until the next accepted start.
module vec_alu_multilane #(
    parameter  int VLEN       = 128,
    parameter  int NB_LANES   = 1,
    parameter  int LANE_WIDTH = 3,
    localparam int VLEN_LOG2  = $clog2(VLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [2:0]        vsew,
    input  logic [VLEN_LOG2:0] vl,
    input  logic              vm,
    input  logic [VLEN-1:0]   mask,
    input  logic [VLEN-1:0]   vs1,
    input  logic [VLEN-1:0]   vs2,
    input  logic [VLEN-1:0]   vd_old,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [VLEN-1:0]   vd
);

    localparam int N   = 1 << NB_LANES;
    localparam int L   = 1 << LANE_WIDTH;
    localparam int LP1 = L + 1;
    localparam int VLW = VLEN_LOG2 + 1;
    localparam int OW  = VLW + 7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000010;
    localparam logic [5:0] OP_AND = 6'b001001;
    localparam logic [5:0] OP_OR  = 6'b001010;
    localparam logic [5:0] OP_XOR = 6'b001011;

    logic [1:0]      state_q;
    logic [5:0]      op_q;
    logic [1:0]      sew_q;
    logic [VLW-1:0]  vl_eff_q;
    logic            vm_q;
    logic [VLEN-1:0] mask_q, vs1_q, vs2_q, vd_q;
    logic            err_q;
    logic [VLW-1:0]  base_q;
    logic [2:0]      k_q;
    logic [N-1:0]    carry_q;

    logic            illegal;
    logic [VLW-1:0]  vlmax, vl_eff_in;
    logic [2:0]      lg_e, lg_cw, lg_k, k_last;
    logic [7:0]      cw;
    logic [L-1:0]    cw_mask;
    logic            is_sub, last_chunk;
    logic [VLEN-1:0] vd_n;
    logic [N-1:0]    carry_n;

    // Decode the request: legality and effective vector length.
    always_comb begin
        illegal   = !((opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) && !vsew[2]);
        vlmax     = VLW'((VLEN / 8) >> vsew[1:0]);
        vl_eff_in = (vl < vlmax) ? vl : vlmax;
    end

    // Chunk geometry for the registered element width.
    always_comb begin
        lg_e       = 3'd3 + {1'b0, sew_q};
        lg_cw      = (lg_e > 3'(LANE_WIDTH)) ? 3'(LANE_WIDTH) : lg_e;
        lg_k       = lg_e - lg_cw;
        k_last     = 3'((4'd1 << lg_k) - 4'd1);
        cw         = 8'd1 << lg_cw;
        cw_mask    = {L{1'b1}} >> (8'(L) - cw);
        is_sub     = (op_q == OP_SUB);
        last_chunk = (k_q == k_last) && ((base_q + VLW'(N)) >= vl_eff_q);
    end

    // Lane datapath: each lane computes one chunk of element base_q+i and merges it into vd.
    always_comb begin
        vd_n    = vd_q;
        carry_n = carry_q;
        for (int i = 0; i < N; i++) begin
            logic [VLW-1:0] j;
            logic [OW-1:0]  off;
            logic           act, cin;
            logic [L-1:0]   a, b, res;
            logic [L:0]     sum;
            j   = base_q + VLW'(i);
            act = (j < vl_eff_q) && (vm_q || 1'(mask_q >> j));
            off = (OW'(j) << lg_e) + (OW'(k_q) << LANE_WIDTH);
            a   = L'(vs2_q >> off) & cw_mask;
            b   = (is_sub ? ~L'(vs1_q >> off) : L'(vs1_q >> off)) & cw_mask;
            // Carry restarts at chunk 0 of every element; subtraction is a + ~b + 1.
            cin = (k_q == 3'd0) ? is_sub : carry_q[i];
            sum = {1'b0, a} + {1'b0, b} + LP1'(cin);
            case (op_q)
                OP_AND:  res = a & b;
                OP_OR:   res = a | b;
                OP_XOR:  res = a ^ b;
                default: res = sum[L-1:0];
            endcase
            if (act && state_q == S_RUN) begin
                vd_n       = (vd_n & ~(VLEN'(cw_mask) << off)) | (VLEN'(res & cw_mask) << off);
                carry_n[i] = 1'(sum >> cw);
            end
        end
    end

    // Control FSM with request capture, chunk/group sequencing and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sew_q    <= '0;
            vl_eff_q <= '0;
            vm_q     <= 1'b0;
            mask_q   <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            err_q    <= 1'b0;
            base_q   <= '0;
            k_q      <= '0;
            carry_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= opcode;
                        sew_q    <= vsew[1:0];
                        vl_eff_q <= vl_eff_in;
                        vm_q     <= vm;
                        mask_q   <= mask;
                        vs1_q    <= vs1;
                        vs2_q    <= vs2;
                        vd_q     <= vd_old;
                        err_q    <= illegal;
                        base_q   <= '0;
                        k_q      <= '0;
                        carry_q  <= '0;
                        state_q  <= (illegal || vl_eff_in == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    vd_q    <= vd_n;
                    carry_q <= carry_n;
                    if (k_q == k_last) begin
                        k_q    <= '0;
                        base_q <= base_q + VLW'(N);
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                    if (last_chunk) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign err  = done & err_q;
    assign vd   = vd_q;

endmodule
